// File: rtl/inst_fetch_pkg.sv
// Shared types and default widths for the instruction fetch unit.
// AddrW/InstW are shared with the instruction ROM and the top level.
package inst_fetch_pkg;

  localparam int unsigned AddrW  = 10;
  localparam int unsigned InstW  = 9;
  localparam int unsigned CountW = 16;

  // Default instruction encoding that terminates a run.
  localparam logic [InstW-1:0] HaltWordDefault = '1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalted
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch unit: requesting end of a combinational instruction ROM.
// Owns the PC, registers the returned word into a one-stage fetch register and
// handles stall, branch/jump redirect with squash, halt detection and
// Start/Done sequencing.
//
// Ports:
//   clk_i            clock, all state updates on rising edge
//   rst_ni           synchronous active-low reset
//   start_i          begin a run at start_addr_i (IDLE/HALTED only)
//   start_addr_i     first fetch address
//   stall_i          hold PC and fetch register
//   branch_taken_i   relative redirect to inst_pc_o + branch_offset_i
//   branch_offset_i  two's-complement branch offset
//   jump_taken_i     absolute redirect to jump_target_i (wins over branch)
//   jump_target_i    absolute target address
//   inst_i           ROM word for inst_addr_o, same cycle
//   inst_addr_o      PC register
//   instruction_o    fetch register contents
//   inst_pc_o        address instruction_o was fetched from
//   inst_valid_o     instruction_o is live
//   running_o        in RUN
//   done_o           in HALTED
//   cycle_count_o    RUN cycles this run, saturating
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned   A        = AddrW,
  parameter int unsigned   W        = InstW,
  parameter int unsigned   CW       = CountW,
  parameter logic [W-1:0]  HaltWord = {W{1'b1}}
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [A-1:0]  start_addr_i,
  input  logic          stall_i,
  input  logic          branch_taken_i,
  input  logic [A-1:0]  branch_offset_i,
  input  logic          jump_taken_i,
  input  logic [A-1:0]  jump_target_i,
  input  logic [W-1:0]  inst_i,
  output logic [A-1:0]  inst_addr_o,
  output logic [W-1:0]  instruction_o,
  output logic [A-1:0]  inst_pc_o,
  output logic          inst_valid_o,
  output logic          running_o,
  output logic          done_o,
  output logic [CW-1:0] cycle_count_o
);

  fetch_state_t  state_q, state_d;
  logic [A-1:0]  pc_q, pc_d;
  logic [W-1:0]  instr_q, instr_d;
  logic [A-1:0]  inst_pc_q, inst_pc_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] count_q, count_d;

  logic          redirect;
  logic          halt_live;
  logic [A-1:0]  target;

  // Redirects come from the decoder acting on the live word, so they mean
  // nothing while the fetch register is empty or squashed.
  assign redirect  = valid_q & (jump_taken_i | branch_taken_i);
  assign halt_live = valid_q & (instr_q == HaltWord);
  // Offset has the PC's width, so a plain A-bit add is the sign-extended sum mod 2^A.
  assign target    = jump_taken_i ? jump_target_i : inst_pc_q + branch_offset_i;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    count_d   = count_q;

    unique case (state_q)
      StIdle, StHalted: begin
        if (start_i) begin
          state_d = StRun;
          pc_d    = start_addr_i;
          valid_d = 1'b0;
          count_d = '0;
        end
      end
      StRun: begin
        if (count_q != {CW{1'b1}}) begin
          count_d = count_q + 1'b1;
        end
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
        end else if (halt_live) begin
          // PC was already held while the halt sat in the register.
          state_d = StHalted;
          valid_d = 1'b0;
        end else if (!stall_i) begin
          instr_d   = inst_i;
          inst_pc_d = pc_q;
          valid_d   = 1'b1;
          pc_d      = pc_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      instr_q   <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  assign inst_addr_o   = pc_q;
  assign instruction_o = instr_q;
  assign inst_pc_o     = inst_pc_q;
  assign inst_valid_o  = valid_q;
  assign running_o     = (state_q == StRun);
  assign done_o        = (state_q == StHalted);
  assign cycle_count_o = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  start_addr;
  logic        stall;
  logic        br;
  logic [9:0]  br_off;
  logic        jmp;
  logic [9:0]  jmp_tgt;
  logic [8:0]  inst;
  logic [9:0]  inst_addr;
  logic [8:0]  instruction;
  logic [9:0]  inst_pc;
  logic        inst_valid;
  logic        running;
  logic        done;
  logic [15:0] cycle_count;

  logic [8:0]  rom [1024];

  int errors = 0;
  int checks = 0;

  // Reference model state: mode 0 idle, 1 running, 2 halted.
  int          m_mode;
  logic [9:0]  m_pc;
  logic [9:0]  m_ipc;
  logic [8:0]  m_instr;
  logic        m_valid;
  int          m_cnt;

  inst_fetch dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .start_addr_i    (start_addr),
    .stall_i         (stall),
    .branch_taken_i  (br),
    .branch_offset_i (br_off),
    .jump_taken_i    (jmp),
    .jump_target_i   (jmp_tgt),
    .inst_i          (inst),
    .inst_addr_o     (inst_addr),
    .instruction_o   (instruction),
    .inst_pc_o       (inst_pc),
    .inst_valid_o    (inst_valid),
    .running_o       (running),
    .done_o          (done),
    .cycle_count_o   (cycle_count)
  );

  always_comb inst = rom[inst_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rn;
    logic       st;
    logic [9:0] sa;
    logic       sl;
    logic       b;
    logic [9:0] of;
    logic       j;
    logic [9:0] tg;
    logic       ev;
    logic [9:0] eipc;
    logic       er;
    logic       ed;
    logic [9:0] ea;
    int         ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rn, logic st, logic [9:0] sa, logic sl, logic b,
                              logic [9:0] of, logic j, logic [9:0] tg, logic ev,
                              logic [9:0] eipc, logic er, logic ed, logic [9:0] ea, int ec);
    vec_t v;
    v.rn = rn; v.st = st; v.sa = sa; v.sl = sl; v.b = b; v.of = of; v.j = j; v.tg = tg;
    v.ev = ev; v.eipc = eipc; v.er = er; v.ed = ed; v.ea = ea; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // One clock of the reference model, from the fetch rules in plain arithmetic.
  task automatic model_edge(input logic rn, input logic st, input logic [9:0] sa,
                            input logic sl, input logic b, input logic [9:0] of,
                            input logic j, input logic [9:0] tg);
    int t;
    if (!rn) begin
      m_mode = 0; m_pc = '0; m_ipc = '0; m_instr = '0; m_valid = 1'b0; m_cnt = 0;
    end else if (m_mode != 1) begin
      if (st) begin
        m_mode = 1; m_pc = sa; m_valid = 1'b0; m_cnt = 0;
      end
    end else begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (m_valid && (j || b)) begin
        t = (int'(m_ipc) + int'(of)) % 1024;
        m_pc = j ? tg : t[9:0];
        m_valid = 1'b0;
      end else if (m_valid && m_instr == 9'h1FF) begin
        m_mode = 2;
        m_valid = 1'b0;
      end else if (!sl) begin
        m_instr = rom[m_pc];
        m_ipc = m_pc;
        m_valid = 1'b1;
        t = (int'(m_pc) + 1) % 1024;
        m_pc = t[9:0];
      end
    end
  endtask

  task automatic step(input logic rn, input logic st, input logic [9:0] sa, input logic sl,
                      input logic b, input logic [9:0] of, input logic j, input logic [9:0] tg);
    rst_n = rn; start = st; start_addr = sa; stall = sl;
    br = b; br_off = of; jmp = j; jmp_tgt = tg;
    @(posedge clk);
    model_edge(rn, st, sa, sl, b, of, j, tg);
    #1;
    chk("model_ctl", {running, done, inst_valid, inst_addr, cycle_count},
        {m_mode == 1, m_mode == 2, m_valid, m_pc, m_cnt[15:0]});
    if (m_valid) chk("model_inst", {inst_pc, instruction}, {m_ipc, m_instr});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; stall = 1'b0;
    br = 1'b0; br_off = '0; jmp = 1'b0; jmp_tgt = '0;
    m_mode = 0; m_pc = '0; m_ipc = '0; m_instr = '0; m_valid = 1'b0; m_cnt = 0;
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    rom[0] = 9'b011_001_000;
    rom[1] = 9'b011_011_001;
    rom[2] = 9'b000_001_011;
    rom[3] = 9'b110_001_000;
    rom[4] = 9'b1_1111_1111;

    //                rn st sa     sl b  of      j  tg     ev eipc   er ed ea     ec
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,      0, 0,     0, 0,     0, 0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,      0, 0,     0, 0,     0, 0, 0,     0));
    vecs.push_back(mk(1, 1, 0,     0, 0, 0,      0, 0,     0, 0,     1, 0, 0,     0));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 0,     1, 0, 1,     1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 1,     1, 0, 2,    -1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 2,     1, 0, 3,    -1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 3,     1, 0, 4,    -1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 4,     1, 0, 5,     5));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     0, 0,     0, 1, 5,     6));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     0, 0,     0, 1, 5,     6));
    // Restart from HALTED, then stall three cycles on InstPC=2.
    vecs.push_back(mk(1, 1, 0,     0, 0, 0,      0, 0,     0, 0,     1, 0, 0,     0));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 0,     1, 0, 1,    -1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 1,     1, 0, 2,    -1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 2,     1, 0, 3,    -1));
    vecs.push_back(mk(1, 0, 0,     1, 0, 0,      0, 0,     1, 2,     1, 0, 3,    -1));
    vecs.push_back(mk(1, 0, 0,     1, 0, 0,      0, 0,     1, 2,     1, 0, 3,    -1));
    vecs.push_back(mk(1, 0, 0,     1, 0, 0,      0, 0,     1, 2,     1, 0, 3,    -1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 3,     1, 0, 4,    -1));
    // Branch -2 from InstPC=3, then jump to 0 over the live halt word.
    vecs.push_back(mk(1, 0, 0,     0, 1, 10'h3FE, 0, 0,    0, 0,     1, 0, 1,    -1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 1,     1, 0, 2,    -1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 2,     1, 0, 3,    -1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 3,     1, 0, 4,    -1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 4,     1, 0, 5,    -1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      1, 0,     0, 0,     1, 0, 0,    -1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 0,     1, 0, 1,    -1));
    // Jump and branch together: jump wins. Start during RUN is ignored.
    vecs.push_back(mk(1, 0, 0,     0, 1, 1,      1, 2,     0, 0,     1, 0, 2,    -1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 2,     1, 0, 3,    -1));
    vecs.push_back(mk(1, 1, 0,     0, 0, 0,      0, 0,     1, 3,     1, 0, 4,    17));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 4,     1, 0, 5,    -1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     0, 0,     0, 1, 5,    19));
    // PC wrap from 1023, then reset mid-run at InstPC=2 (overrides Start).
    vecs.push_back(mk(1, 1, 1023,  0, 0, 0,      0, 0,     0, 0,     1, 0, 1023,  0));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 1023,  1, 0, 0,    -1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 0,     1, 0, 1,    -1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 1,     1, 0, 2,    -1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 2,     1, 0, 3,    -1));
    vecs.push_back(mk(0, 1, 0,     0, 0, 0,      0, 0,     0, 0,     0, 0, 0,     0));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     0, 0,     0, 0, 0,     0));
    // Jump with nothing live is ignored; redirect beats stall.
    vecs.push_back(mk(1, 1, 0,     0, 0, 0,      0, 0,     0, 0,     1, 0, 0,     0));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      1, 7,     1, 0,     1, 0, 1,    -1));
    vecs.push_back(mk(1, 0, 0,     1, 1, 2,      0, 0,     0, 0,     1, 0, 2,    -1));
    vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0, 0,     1, 2,     1, 0, 3,    -1));

    foreach (vecs[k]) begin
      vec_t v;
      v = vecs[k];
      step(v.rn, v.st, v.sa, v.sl, v.b, v.of, v.j, v.tg);
      chk($sformatf("vec%0d_valid", k), 32'(inst_valid), 32'(v.ev));
      chk($sformatf("vec%0d_running", k), 32'(running), 32'(v.er));
      chk($sformatf("vec%0d_done", k), 32'(done), 32'(v.ed));
      chk($sformatf("vec%0d_addr", k), 32'(inst_addr), 32'(v.ea));
      if (v.ev) begin
        chk($sformatf("vec%0d_pc", k), 32'(inst_pc), 32'(v.eipc));
        chk($sformatf("vec%0d_instr", k), 32'(instruction), 32'(rom[v.eipc]));
      end
      if (v.ec >= 0) chk($sformatf("vec%0d_count", k), 32'(cycle_count), v.ec);
      if (!v.rn) begin
        chk($sformatf("vec%0d_rst_pc", k), 32'(inst_pc), 32'd0);
        chk($sformatf("vec%0d_rst_instr", k), 32'(instruction), 32'd0);
      end
    end

    // Random phase: scattered halt words, random redirects, stalls, starts, resets.
    for (int i = 0; i < 1024; i++) begin
      rom[i] = ($urandom_range(0, 11) == 0) ? 9'h1FF : 9'($urandom);
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 9) == 0,
           10'($urandom),
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0,
           10'($urandom_range(0, 15)) - 10'd8,
           $urandom_range(0, 11) == 0,
           10'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
